// File: rtl/modexp_param.sv
// Modular exponentiation core: result = message^exponent mod modulus.
// Left-to-right square-and-multiply over a bit-serial interleaved modular
// multiplier that consumes one multiplier bit per clock.
module modexp_param #(
  parameter int WIDTH     = 4096,
  parameter int EXP_WIDTH = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     message,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SQR,
    S_MUL,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  // Captured operands
  logic [WIDTH-1:0]     r_msg;
  logic [WIDTH-1:0]     r_mod;
  logic [EXP_WIDTH-1:0] r_exp;   // shifted left; MSB is the current bit k
  logic [KW-1:0]        r_k;     // remaining exponent bits after the current one

  // Exponentiation / multiplier state
  logic [WIDTH-1:0]     r_acc;   // running power
  logic [WIDTH-1:0]     r_p;     // partial product, always < modulus
  logic [WIDTH-1:0]     r_a;     // multiplier operand, shifted left, MSB consumed
  logic [CW-1:0]        r_cnt;   // multiplier bits still to process after this one

  // Registered outputs
  logic [WIDTH-1:0]     r_result;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  // Conditional subtract keeping a WIDTH+1 bit intermediate below the modulus
  function automatic logic [WIDTH:0] f_mod_reduce(input logic [WIDTH:0] x,
                                                  input logic [WIDTH:0] m);
    f_mod_reduce = (x >= m) ? (x - m) : x;
  endfunction

  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_dbl_red;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_add_red;
  logic [WIDTH-1:0] w_p_next;
  logic             w_op_last;
  logic             w_exp_bit;
  logic             w_k_last;
  logic             w_bad;
  logic             w_mod_one;

  assign w_m_ext   = {1'b0, r_mod};
  // Squaring multiplies acc by itself; the multiply step uses the base
  assign w_b       = (r_state == S_MUL) ? r_msg : r_acc;
  assign w_dbl     = {r_p, 1'b0};
  assign w_dbl_red = f_mod_reduce(w_dbl, w_m_ext);
  assign w_add     = w_dbl_red + (r_a[WIDTH-1] ? {1'b0, w_b} : {(WIDTH+1){1'b0}});
  assign w_add_red = f_mod_reduce(w_add, w_m_ext);
  assign w_p_next  = w_add_red[WIDTH-1:0];
  assign w_op_last = (r_cnt == '0);
  assign w_exp_bit = r_exp[EXP_WIDTH-1];
  assign w_k_last  = (r_k == '0);
  assign w_bad     = (r_mod == '0) || (r_msg >= r_mod);
  assign w_mod_one = (r_mod == WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; abort wins over any progress while busy
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: begin
        if (abort)                      w_next = S_IDLE;
        else if (w_bad || w_mod_one)    w_next = S_FIN;
        else                            w_next = S_SQR;
      end
      S_SQR: begin
        if (abort)                      w_next = S_IDLE;
        else if (w_op_last) begin
          if (w_exp_bit)                w_next = S_MUL;
          else if (w_k_last)            w_next = S_FIN;
          else                          w_next = S_SQR;
        end
      end
      S_MUL: begin
        if (abort)                      w_next = S_IDLE;
        else if (w_op_last)             w_next = w_k_last ? S_FIN : S_SQR;
      end
      S_FIN:                            w_next = S_IDLE;
      default:                          w_next = S_IDLE;
    endcase
  end

  // Operand capture, multiplier iteration and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msg    <= '0;
      r_mod    <= '0;
      r_exp    <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_p      <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_msg  <= message;
            r_exp  <= exponent;
            r_mod  <= modulus;
            r_busy <= 1'b1;
          end
        end
        S_CHECK: begin
          if (abort) begin
            r_busy <= 1'b0;
          end else if (w_bad || w_mod_one) begin
            r_result <= '0;
            r_done   <= 1'b1;
            r_err    <= w_bad;
            r_busy   <= 1'b0;
          end else begin
            r_acc <= WIDTH'(1);
            r_a   <= WIDTH'(1);
            r_p   <= '0;
            r_cnt <= CW'(WIDTH - 1);
            r_k   <= KW'(EXP_WIDTH - 1);
          end
        end
        S_SQR, S_MUL: begin
          if (abort) begin
            r_busy <= 1'b0;
          end else if (!w_op_last) begin
            r_p   <= w_p_next;
            r_a   <= r_a << 1;
            r_cnt <= r_cnt - CW'(1);
          end else begin
            // Product complete: it becomes acc and the next multiplier operand
            r_acc <= w_p_next;
            r_a   <= w_p_next;
            r_p   <= '0;
            r_cnt <= CW'(WIDTH - 1);
            if ((r_state == S_MUL) || !w_exp_bit) begin
              r_exp <= r_exp << 1;
              r_k   <= r_k - KW'(1);
            end
            if (w_next == S_FIN) begin
              r_result <= w_p_next;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
            end
          end
        end
        S_FIN: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_modexp_param.sv
// Bench for modexp_param: directed table on an 8-bit instance, abort/restart/
// reset sequences, then randomized 64-bit vectors against a plain-arithmetic model.
module tb_modexp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, abort, sel64;
  logic [63:0] t_msg, t_mod;
  logic [7:0]  t_exp;

  logic [7:0]  res8;
  logic        busy8, done8, err8;
  logic [63:0] res64;
  logic        busy64, done64, err64;

  logic [63:0] o_res;
  logic        o_busy, o_done, o_err;

  modexp_param #(.WIDTH(8), .EXP_WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel64), .abort(abort & ~sel64),
    .message(t_msg[7:0]), .exponent(t_exp), .modulus(t_mod[7:0]),
    .result(res8), .busy(busy8), .done(done8), .err(err8)
  );

  modexp_param #(.WIDTH(64), .EXP_WIDTH(5)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .start(start & sel64), .abort(abort & sel64),
    .message(t_msg), .exponent(t_exp[4:0]), .modulus(t_mod),
    .result(res64), .busy(busy64), .done(done64), .err(err64)
  );

  assign o_res  = sel64 ? res64  : {56'b0, res8};
  assign o_busy = sel64 ? busy64 : busy8;
  assign o_done = sel64 ? done64 : done8;
  assign o_err  = sel64 ? err64  : err8;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: base^e mod m by repeated multiplication in 128-bit arithmetic
  function automatic void ref_model(input logic [63:0] b, input int e, input logic [63:0] m,
                                    input int w, input int ew,
                                    output logic [63:0] r, output logic er, output int lat);
    logic [127:0] acc;
    if (m == 0 || b >= m) begin
      r = 0; er = 1'b1; lat = 2;
    end else if (m == 1) begin
      r = 0; er = 1'b0; lat = 2;
    end else begin
      acc = 128'd1;
      for (int i = 0; i < e; i++) acc = (acc * {64'd0, b}) % {64'd0, m};
      r = acc[63:0]; er = 1'b0;
      lat = 2 + w * (ew + $countones(e));
    end
  endfunction

  // Start one operation and follow it cycle by cycle (cycle 1 = first after accept)
  task automatic run(input logic [63:0] msg, input logic [7:0] e, input logic [63:0] m,
                     input int abort_at, input int restart_at, input int reset_at,
                     input bit start_in_fin,
                     output logic [63:0] r, output logic er, output int lat,
                     output bit busy_ok, output bit finished);
    int w, ew, budget;
    w = sel64 ? 64 : 8;
    ew = sel64 ? 5 : 8;
    budget = 2 + w * 2 * ew + 20;
    finished = 0; busy_ok = 1; lat = 0; r = 0; er = 0;
    @(negedge clk);
    t_msg = msg; t_exp = e; t_mod = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_msg = {$urandom, $urandom}; t_exp = 8'($urandom); t_mod = {$urandom, $urandom};
    for (int c = 1; c <= budget; c++) begin
      if (o_done) begin
        finished = 1; lat = c; r = o_res; er = o_err;
        if (o_busy) busy_ok = 0;
        if (start_in_fin) begin
          start = 1'b1; abort = 1'b1;
          t_msg = 64'd3; t_exp = 8'd1; t_mod = 64'd7;
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("done_pulse_width", {63'd0, o_done}, 64'd0);
        check("busy_after_fin", {63'd0, o_busy}, 64'd0);
        return;
      end
      if (!o_busy) busy_ok = 0;
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        return;
      end
      if (c == reset_at) begin
        reset_n = 1'b0;
        #1;
        return;
      end
      if (c == restart_at) begin
        start = 1'b1; t_msg = 64'd3; t_exp = 8'd1; t_mod = 64'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic do_vec(input string name, input logic [63:0] msg, input logic [7:0] e,
                        input logic [63:0] m, input logic [63:0] x_res, input logic x_err,
                        input int x_lat, input bit start_in_fin, input int restart_at);
    logic [63:0] r; logic er; int lat; bit bok, fin;
    run(msg, e, m, 0, restart_at, 0, start_in_fin, r, er, lat, bok, fin);
    check({name, "_finished"}, {63'd0, fin}, 64'd1);
    check({name, "_result"}, r, x_res);
    check({name, "_err"}, {63'd0, er}, {63'd0, x_err});
    check({name, "_latency"}, 64'(lat), 64'(x_lat));
    check({name, "_busy"}, {63'd0, bok}, 64'd1);
  endtask

  typedef struct {
    logic [63:0] msg;
    logic [7:0]  e;
    logic [63:0] m;
    logic [63:0] res;
    logic        er;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [63:0] r, m, b, xr;
    logic er, xer;
    int lat, xlat, e;
    bit bok, fin, seen;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; sel64 = 1'b0;
    t_msg = '0; t_exp = '0; t_mod = '0;
    repeat (3) @(negedge clk);
    check("rst8_result", {56'd0, res8}, 64'd0);
    check("rst8_busy", {63'd0, busy8}, 64'd0);
    check("rst8_done", {63'd0, done8}, 64'd0);
    check("rst8_err", {63'd0, err8}, 64'd0);
    check("rst64_result", res64, 64'd0);
    reset_n = 1'b1;

    // Directed table on WIDTH=8, EXP_WIDTH=8
    tbl.push_back('{64'd8,  8'd13,  64'd77, 64'd50, 1'b0, 90});
    tbl.push_back('{64'd50, 8'd37,  64'd77, 64'd8,  1'b0, 90});
    tbl.push_back('{64'd5,  8'd0,   64'd77, 64'd1,  1'b0, 66});
    tbl.push_back('{64'd0,  8'd3,   64'd1,  64'd0,  1'b0, 2});
    tbl.push_back('{64'd80, 8'd3,   64'd77, 64'd0,  1'b1, 2});
    tbl.push_back('{64'd5,  8'd3,   64'd0,  64'd0,  1'b1, 2});
    tbl.push_back('{64'd77, 8'd3,   64'd77, 64'd0,  1'b1, 2});
    tbl.push_back('{64'd76, 8'd2,   64'd77, 64'd1,  1'b0, 74});
    tbl.push_back('{64'd0,  8'd5,   64'd77, 64'd0,  1'b0, 82});
    tbl.push_back('{64'd3,  8'd255, 64'd7,  64'd6,  1'b0, 130});
    foreach (tbl[i])
      do_vec($sformatf("tbl%0d", i), tbl[i].msg, tbl[i].e, tbl[i].m,
             tbl[i].res, tbl[i].er, tbl[i].lat, 1'b0, 0);

    // Abort at cycle 40: busy drops, no done, previous result (6) held
    run(64'd8, 8'd13, 64'd77, 40, 0, 0, 1'b0, r, er, lat, bok, fin);
    check("abort_busy_low", {63'd0, busy8}, 64'd0);
    check("abort_no_done_yet", {63'd0, fin}, 64'd0);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (done8 || busy8) seen = 1;
      @(negedge clk);
    end
    check("abort_stays_idle", {63'd0, seen}, 64'd0);
    check("abort_result_held", {56'd0, res8}, 64'd6);

    // Fresh start after abort, with a stray start mid-run and start+abort in FIN
    do_vec("restart", 64'd8, 8'd13, 64'd77, 64'd50, 1'b0, 90, 1'b1, 20);

    // Async reset mid-run clears outputs before the next clock edge
    run(64'd50, 8'd37, 64'd77, 0, 0, 30, 1'b0, r, er, lat, bok, fin);
    check("midrst_result", {56'd0, res8}, 64'd0);
    check("midrst_busy", {63'd0, busy8}, 64'd0);
    check("midrst_done", {63'd0, done8}, 64'd0);
    check("midrst_err", {63'd0, err8}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_vec("post_rst", 64'd50, 8'd37, 64'd77, 64'd8, 1'b0, 90, 1'b0, 0);

    // Randomized WIDTH=64, EXP_WIDTH=5 against the reference model
    sel64 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      m = {$urandom, $urandom};
      e = int'($urandom_range(0, 31));
      if (i < 2 || i == 10) m = 64'hFFFF_FFFF_FFFF_FFC5;
      else if (i % 20 == 5) m = 64'($urandom_range(1, 3));
      b = (m != 0) ? ({$urandom, $urandom} % m) : {$urandom, $urandom};
      if (i == 0 || i == 2) b = m - 64'd1;
      if (i == 0) e = 31;
      if (i % 20 == 7) b = m;
      ref_model(b, e, m, 64, 5, xr, xer, xlat);
      do_vec($sformatf("rand%0d", i), b, 8'(e), m, xr, xer, xlat, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
